mult_issue_taint_track: RTL and testbench
=========================================

Name: mult_issue_taint_track

Overview:
- Handshake front-end that sits directly upstream of the taint-tracked sequential multiplier.
- Accepts one operand pair per transaction over valid/ready and latches it with its bitwise taint.
- Pulses start for one cycle, then waits for productDone and captures product with its taint.
- Presents the captured result downstream over valid/ready.
- Propagates control-flow taint: any tainted handshake or done signal that steers the FSM taints every control output and the captured result.

Parameters:
- WIDTH, 128, operand width; product width is 2*WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid / in_valid_t  in  1 / 1  operand pair valid; taint
- in_multiplier / in_multiplier_t  in  WIDTH / WIDTH  operand A; bitwise taint
- in_multiplicand / in_multiplicand_t  in  WIDTH / WIDTH  operand B; bitwise taint
- in_ready / in_ready_t  out  1 / 1  operand accept; taint
- start / start_t  out  1 / 1  to multiplier; taint
- multiplier / multiplier_t  out  WIDTH / WIDTH  latched operand A; taint
- multiplicand / multiplicand_t  out  WIDTH / WIDTH  latched operand B; taint
- product / product_t  in  2*WIDTH / 2*WIDTH  from multiplier; taint
- productDone / productDone_t  in  1 / 1  from multiplier; taint
- out_valid / out_valid_t  out  1 / 1  result valid; taint
- out_product / out_product_t  out  2*WIDTH / 2*WIDTH  captured result; taint
- out_ready / out_ready_t  in  1 / 1  downstream accept; taint

Behaviour:
- Reset (rst=1 at posedge, any state):
  - state=IDLE, ctrl_t=0.
  - All operand/result registers and their taints = 0.
  - start=0, out_valid=0, in_ready=1; all *_t outputs 0.
- Reset mid-operation abandons the transaction; no out_valid follows.
- States:
  - IDLE: in_ready=1. On in_valid=1, latch both operands and their taints, then go to ISSUE.
  - ISSUE: start=1 for exactly one cycle, then go to ARM.
  - ARM: one cycle in which productDone is ignored, so a stale done from the previous operation is never taken. Then go to WAIT.
  - WAIT: on productDone=1, capture out_product=product and out_product_t = product_t | {2*WIDTH{ctrl_t_next}}, then go to HOLD. Otherwise stay.
  - HOLD: out_valid=1. On out_ready=1, go to IDLE. Otherwise hold out_product stable.
- in_ready=1 only in IDLE; there is no accept-while-busy and no result bypass.
- Accept-to-start latency: 1 cycle. start to first possible done sample: 2 cycles. Done to out_valid: 1 cycle.
- multiplier/multiplicand outputs hold their latched values from accept until the next accept.
- Control taint ctrl_t is sticky. It is set (OR) when a tainted input is sampled at a decision point:
  - in_valid_t in IDLE;
  - productDone_t in WAIT;
  - out_ready_t in HOLD.
  ctrl_t_next is ctrl_t including the current cycle's contribution.
- While ctrl_t=1: in_ready_t=start_t=out_valid_t=1 in every state.
- While ctrl_t=0: those taints are 0.
- Operand taint is pure bitwise copy; it never includes ctrl_t.

Optional Feature:
- CTRL_TAINT_DECLASSIFY_EN defined: ctrl_t clears on the HOLD->IDLE transition. A new transaction therefore starts untainted unless its own inputs are tainted.
- Not defined: ctrl_t clears only on rst.
- Both builds: out_product_t captured during a tainted transaction remains as captured until the next capture.

Test Plan (WIDTH=8):
- Untainted op: A=0x0D, B=0x07, all taints 0; model multiplier returns 0x005B with done 8 cycles after start. Expect:
  - start high exactly one cycle, one cycle after accept;
  - out_valid one cycle after done, with out_product=0x005B;
  - every *_t = 0.
- Bitwise data taint: A_t=0x01, B_t=0x00, model product_t=0x00FF. Expect multiplier_t=0x01, out_product_t=0x00FF, out_valid_t=0.
- Tainted done: productDone_t=1 at capture. Expect:
  - out_product_t=0xFFFF;
  - out_valid_t=1, and in_ready_t=1 after return to IDLE;
  - next clean op: taints stay 1 without macro, 0 with CTRL_TAINT_DECLASSIFY_EN.
- Backpressure/stale done: hold productDone=1 through ISSUE/ARM. Expect no capture before WAIT. Hold out_ready=0 for 5 cycles: out_valid and out_product stable, in_ready=0, no second accept.
- Reset mid-WAIT: assert rst 3 cycles after start. Expect:
  - next cycle state IDLE, in_ready=1, ctrl_t=0;
  - all outputs and taints zero;
  - no out_valid ever issued for the abandoned op.

Source files
------------

// File: rtl/mult_issue_taint_track.sv
`default_nettype none
// ============================================================================
//  Module   : mult_issue_taint_track
//  Purpose  : Valid/ready issue front-end for the taint-tracked multiplier.
//             Define CTRL_TAINT_DECLASSIFY_EN to clear control taint on
//             HOLD->IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_issue_taint_track #(
    parameter int WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_valid_t,
    input  logic [WIDTH-1:0]     in_multiplier,
    input  logic [WIDTH-1:0]     in_multiplier_t,
    input  logic [WIDTH-1:0]     in_multiplicand,
    input  logic [WIDTH-1:0]     in_multiplicand_t,
    output logic                 in_ready,
    output logic                 in_ready_t,
    output logic                 start,
    output logic                 start_t,
    output logic [WIDTH-1:0]     multiplier,
    output logic [WIDTH-1:0]     multiplier_t,
    output logic [WIDTH-1:0]     multiplicand,
    output logic [WIDTH-1:0]     multiplicand_t,
    input  logic [2*WIDTH-1:0]   product,
    input  logic [2*WIDTH-1:0]   product_t,
    input  logic                 productDone,
    input  logic                 productDone_t,
    output logic                 out_valid,
    output logic                 out_valid_t,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [2*WIDTH-1:0]   out_product_t,
    input  logic                 out_ready,
    input  logic                 out_ready_t
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]         r_state;
    logic               r_ctrl_t;
    logic [WIDTH-1:0]   r_multiplier;
    logic [WIDTH-1:0]   r_multiplier_t;
    logic [WIDTH-1:0]   r_multiplicand;
    logic [WIDTH-1:0]   r_multiplicand_t;
    logic [2*WIDTH-1:0] r_out_product;
    logic [2*WIDTH-1:0] r_out_product_t;
    logic               w_ctrl_t_next;

    // Only signals that actually steer the FSM in the current state taint control.
    always_comb begin
        w_ctrl_t_next = r_ctrl_t;
        case (r_state)
            S_IDLE:  w_ctrl_t_next = r_ctrl_t | in_valid_t;
            S_WAIT:  w_ctrl_t_next = r_ctrl_t | productDone_t;
            S_HOLD:  w_ctrl_t_next = r_ctrl_t | out_ready_t;
            default: w_ctrl_t_next = r_ctrl_t;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_ctrl_t         <= 1'b0;
            r_multiplier     <= '0;
            r_multiplier_t   <= '0;
            r_multiplicand   <= '0;
            r_multiplicand_t <= '0;
            r_out_product    <= '0;
            r_out_product_t  <= '0;
        end else begin
            r_ctrl_t <= w_ctrl_t_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_multiplier     <= in_multiplier;
                        r_multiplier_t   <= in_multiplier_t;
                        r_multiplicand   <= in_multiplicand;
                        r_multiplicand_t <= in_multiplicand_t;
                        r_state          <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_ARM;
                // ARM lets a stale done from the previous operation drain unseen.
                S_ARM:   r_state <= S_WAIT;
                S_WAIT: begin
                    if (productDone) begin
                        r_out_product   <= product;
                        r_out_product_t <= product_t | {(2*WIDTH){w_ctrl_t_next}};
                        r_state         <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
`ifdef CTRL_TAINT_DECLASSIFY_EN
                        r_ctrl_t <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready       = (r_state == S_IDLE);
    assign start          = (r_state == S_ISSUE);
    assign out_valid      = (r_state == S_HOLD);
    assign in_ready_t     = r_ctrl_t;
    assign start_t        = r_ctrl_t;
    assign out_valid_t    = r_ctrl_t;
    assign multiplier     = r_multiplier;
    assign multiplier_t   = r_multiplier_t;
    assign multiplicand   = r_multiplicand;
    assign multiplicand_t = r_multiplicand_t;
    assign out_product    = r_out_product;
    assign out_product_t  = r_out_product_t;

endmodule
`default_nettype wire

// File: tb/tb_mult_issue_taint_track.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_issue_taint_track
//  Purpose  : Self-checking bench: directed taint scenarios plus random traffic
//             against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_issue_taint_track;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0, in_valid_t = 1'b0;
    logic [WIDTH-1:0]   in_multiplier = '0, in_multiplier_t = '0;
    logic [WIDTH-1:0]   in_multiplicand = '0, in_multiplicand_t = '0;
    logic               in_ready, in_ready_t, start, start_t;
    logic [WIDTH-1:0]   multiplier, multiplier_t, multiplicand, multiplicand_t;
    logic [2*WIDTH-1:0] product = '0, product_t = '0;
    logic               productDone = 1'b0, productDone_t = 1'b0;
    logic               out_valid, out_valid_t;
    logic [2*WIDTH-1:0] out_product, out_product_t;
    logic               out_ready = 1'b0, out_ready_t = 1'b0;

    int tests = 0;
    int fails = 0;

    mult_issue_taint_track #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_multiplier(in_multiplier), .in_multiplier_t(in_multiplier_t),
        .in_multiplicand(in_multiplicand), .in_multiplicand_t(in_multiplicand_t),
        .in_ready(in_ready), .in_ready_t(in_ready_t),
        .start(start), .start_t(start_t),
        .multiplier(multiplier), .multiplier_t(multiplier_t),
        .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
        .product(product), .product_t(product_t),
        .productDone(productDone), .productDone_t(productDone_t),
        .out_valid(out_valid), .out_valid_t(out_valid_t),
        .out_product(out_product), .out_product_t(out_product_t),
        .out_ready(out_ready), .out_ready_t(out_ready_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: transaction view of the front-end. age counts cycles
    // since the operand pair was accepted (1 = issue cycle).
    bit               m_ok = 1'b0;
    bit               m_busy = 1'b0, m_have = 1'b0, m_ctrl = 1'b0;
    int               m_age = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0, m_at = '0, m_bt = '0;
    logic [15:0]      m_p = '0, m_pt = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1; m_busy = 1'b0; m_have = 1'b0; m_ctrl = 1'b0; m_age = 0;
            m_a = '0; m_b = '0; m_at = '0; m_bt = '0; m_p = '0; m_pt = '0;
        end else if (!m_busy) begin
            if (in_valid_t) m_ctrl = 1'b1;
            if (in_valid) begin
                m_a = in_multiplier; m_at = in_multiplier_t;
                m_b = in_multiplicand; m_bt = in_multiplicand_t;
                m_busy = 1'b1; m_age = 1;
            end
        end else if (m_have) begin
            if (out_ready_t) m_ctrl = 1'b1;
            if (out_ready) begin
                m_busy = 1'b0; m_have = 1'b0;
`ifdef CTRL_TAINT_DECLASSIFY_EN
                m_ctrl = 1'b0;
`endif
            end
        end else if (m_age >= 3) begin
            if (productDone_t) m_ctrl = 1'b1;
            if (productDone) begin
                m_p = product;
                m_pt = product_t | (m_ctrl ? 16'hFFFF : 16'h0000);
                m_have = 1'b1;
            end
        end else begin
            m_age = m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_ctrl", {26'd0, in_ready, start, out_valid, in_ready_t, start_t, out_valid_t},
                {26'd0, !m_busy, m_busy && !m_have && m_age == 1, m_have, m_ctrl, m_ctrl, m_ctrl});
            chk("model_operands", {multiplier, multiplicand, multiplier_t, multiplicand_t},
                {m_a, m_b, m_at, m_bt});
            chk("model_result", {out_product, out_product_t}, {m_p, m_pt});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with a modelled multiplier: done 8 cycles after start.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] at,
                          input logic [7:0] bt, input logic [15:0] p, input logic [15:0] pt,
                          input logic dt, input bit stale, input int hold,
                          input logic [15:0] exp_ot, input logic exp_ct);
        in_valid = 1'b1; in_multiplier = a; in_multiplicand = b;
        in_multiplier_t = at; in_multiplicand_t = bt;
        step();
        in_valid = 1'b0;
        chk("start_after_accept", {31'd0, start}, 32'd1);
        chk("start_t", {31'd0, start_t}, {31'd0, exp_ct});
        chk("multiplier_latched", {24'd0, multiplier}, {24'd0, a});
        chk("multiplier_t", {24'd0, multiplier_t}, {24'd0, at});
        if (stale) begin productDone = 1'b1; product = 16'hDEAD; end
        step();
        chk("start_one_cycle", {31'd0, start}, 32'd0);
        step();
        productDone = 1'b0;
        chk("no_early_capture", {31'd0, out_valid}, 32'd0);
        repeat (6) step();
        productDone = 1'b1; productDone_t = dt; product = p; product_t = pt;
        step();
        productDone = 1'b0; productDone_t = 1'b0;
        product = 16'h1234; product_t = '0;
        chk("out_valid_after_done", {31'd0, out_valid}, 32'd1);
        chk("out_product", {16'd0, out_product}, {16'd0, p});
        chk("out_product_t", {16'd0, out_product_t}, {16'd0, exp_ot});
        chk("out_valid_t", {31'd0, out_valid_t}, {31'd0, exp_ct | dt});
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_product", {16'd0, out_product}, {16'd0, p});
            chk("hold_no_accept", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("back_to_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic exp_after;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("reset_ctrl", {28'd0, in_ready, start, out_valid, in_ready_t}, 32'h8);
        chk("reset_data", {out_product, out_product_t}, 32'd0);

        // untainted op
        run_op(8'h0D, 8'h07, 8'h00, 8'h00, 16'h005B, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 1'b0);
        // bitwise data taint
        run_op(8'h0D, 8'h07, 8'h01, 8'h00, 16'h005B, 16'h00FF, 1'b0, 1'b0, 0, 16'h00FF, 1'b0);
        // tainted done
        run_op(8'h03, 8'h05, 8'h00, 8'h00, 16'h000F, 16'h0000, 1'b1, 1'b0, 0, 16'hFFFF, 1'b0);
`ifdef CTRL_TAINT_DECLASSIFY_EN
        exp_after = 1'b0;
`else
        exp_after = 1'b1;
`endif
        chk("in_ready_t_after_taint", {31'd0, in_ready_t}, {31'd0, exp_after});
        run_op(8'h02, 8'h02, 8'h00, 8'h00, 16'h0004, 16'h0000, 1'b0, 1'b0, 0,
               exp_after ? 16'hFFFF : 16'h0000, exp_after);

        // stale done + backpressure from a clean state
        rst = 1'b1; step(); rst = 1'b0;
        run_op(8'h11, 8'h02, 8'h00, 8'h00, 16'h0022, 16'h0000, 1'b0, 1'b1, 5, 16'h0000, 1'b0);

        // reset three cycles after start, with done pending
        in_valid = 1'b1; in_multiplier = 8'hAA; in_multiplicand = 8'h55;
        in_multiplier_t = 8'hF0; in_valid_t = 1'b1;
        step();
        in_valid = 1'b0; in_valid_t = 1'b0; in_multiplier_t = '0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_ctrl", {28'd0, in_ready, start, out_valid, in_ready_t}, 32'h8);
        chk("rst_mid_ops", {multiplier, multiplier_t, multiplicand, 8'h00}, 32'd0);
        chk("rst_mid_result", {out_product, out_product_t}, 32'd0);
        productDone = 1'b1; product = 16'h3872;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abandoned_no_valid", {31'd0, out_valid}, 32'd0);
        end
        productDone = 1'b0;

        // random traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst               = ($urandom_range(0, 299) == 0);
            in_valid          = ($urandom_range(0, 2) == 0);
            in_valid_t        = ($urandom_range(0, 39) == 0);
            in_multiplier     = 8'($urandom);
            in_multiplicand   = 8'($urandom);
            in_multiplier_t   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            in_multiplicand_t = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            productDone       = ($urandom_range(0, 3) == 0);
            productDone_t     = ($urandom_range(0, 39) == 0);
            product           = 16'($urandom);
            product_t         = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
            out_ready         = ($urandom_range(0, 1) == 0);
            out_ready_t       = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
